// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-end: FSM states, SSR command
// encodings and the counter width shared with the 99.99 s counter.
package stopwatch_pkg;

  localparam int COUNT_W = 14;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } state_t;

  localparam logic [2:0] SSR_NONE  = 3'b000;
  localparam logic [2:0] SSR_START = 3'b100;
  localparam logic [2:0] SSR_STOP  = 3'b010;
  localparam logic [2:0] SSR_RESET = 3'b001;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RESET,
    CMD_STOP,
    CMD_START,
    CMD_LAP
  } cmd_t;

  // Only the highest-priority press of a cycle survives; the rest are dropped.
  function automatic cmd_t pick_cmd(input logic p_reset, input logic p_stop,
                                    input logic p_start, input logic p_lap);
    if (p_reset)      return CMD_RESET;
    else if (p_stop)  return CMD_STOP;
    else if (p_start) return CMD_START;
    else if (p_lap)   return CMD_LAP;
    else              return CMD_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button, counter feedback and command/status bundle between the stopwatch
// controller (slave) and its environment (master).
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic               btn_start;
  logic               btn_stop;
  logic               btn_reset;
  logic               btn_lap;
  logic [COUNT_W-1:0] count;
  logic [2:0]         ssr;
  logic               tick;
  logic               wrap;
  logic               lap_valid;
  logic [COUNT_W-1:0] lap_count;
  logic [1:0]         state;

  modport master (
    output btn_start, btn_stop, btn_reset, btn_lap, count,
    input  ssr, tick, wrap, lap_valid, lap_count, state
  );

  modport slave (
    input  btn_start, btn_stop, btn_reset, btn_lap, count,
    output ssr, tick, wrap, lap_valid, lap_count, state
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// One raw button: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any sample matching the current level restarts the stability run.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync_p1;
        press <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: debounced buttons drive the mode FSM, which issues SSR
// commands, a gated count-enable tick and holds a lap snapshot.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int DB_CYCLES = 500_000,
  parameter int MAX_COUNT = 9999
) (
  input  logic     clk,
  input  logic     rst,
  stopwatch_if.slave bus
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(DIV - 1);
  localparam logic [COUNT_W-1:0] TERMINAL   = COUNT_W'(MAX_COUNT);

  logic press_start, press_stop, press_reset, press_lap;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .raw(bus.btn_start), .press(press_start));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk), .rst(rst), .raw(bus.btn_stop), .press(press_stop));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk(clk), .rst(rst), .raw(bus.btn_reset), .press(press_reset));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk(clk), .rst(rst), .raw(bus.btn_lap), .press(press_lap));

  cmd_t               cmd;
  logic               counting;
  state_t             state_q;
  logic [2:0]         ssr_q;
  logic               tick_q;
  logic               wrap_q;
  logic               lap_valid_q;
  logic [COUNT_W-1:0] lap_count_q;
  logic [PW-1:0]      presc;

  assign cmd = pick_cmd(press_reset, press_stop, press_start, press_lap);

  // Count only on edges that start and end in RUNNING/LAP, so no tick can
  // land in the cycle that shows STOPPED or IDLE.
  assign counting = (state_q == ST_RUNNING || state_q == ST_LAP) &&
                    cmd != CMD_RESET && cmd != CMD_STOP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ssr_q       <= SSR_NONE;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      lap_valid_q <= 1'b0;
      lap_count_q <= '0;
      presc       <= '0;
    end else begin
      ssr_q  <= SSR_NONE;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;

      // STOPPED holds the prescaler so a resume keeps the sub-tick phase.
      if (state_q == ST_IDLE || cmd == CMD_RESET) begin
        presc <= '0;
      end else if (counting) begin
        if (presc == PRESC_LAST) begin
          presc  <= '0;
          tick_q <= 1'b1;
          wrap_q <= (bus.count == TERMINAL);
        end else begin
          presc <= presc + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd == CMD_START) begin
            state_q <= ST_RUNNING;
            ssr_q   <= SSR_START;
          end else if (cmd == CMD_RESET) begin
            ssr_q <= SSR_RESET;
          end
        end
        ST_RUNNING: begin
          case (cmd)
            CMD_RESET: begin
              state_q <= ST_IDLE;
              ssr_q   <= SSR_RESET;
            end
            CMD_STOP: begin
              state_q <= ST_STOPPED;
              ssr_q   <= SSR_STOP;
            end
            CMD_LAP: begin
              state_q     <= ST_LAP;
              lap_count_q <= bus.count;
              lap_valid_q <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_LAP: begin
          case (cmd)
            CMD_RESET: begin
              state_q     <= ST_IDLE;
              ssr_q       <= SSR_RESET;
              lap_valid_q <= 1'b0;
            end
            CMD_STOP: begin
              state_q     <= ST_STOPPED;
              ssr_q       <= SSR_STOP;
              lap_valid_q <= 1'b0;
            end
            CMD_LAP: begin
              state_q     <= ST_RUNNING;
              lap_valid_q <= 1'b0;
            end
            default: ;
          endcase
        end
        ST_STOPPED: begin
          if (cmd == CMD_RESET) begin
            state_q <= ST_IDLE;
            ssr_q   <= SSR_RESET;
          end else if (cmd == CMD_START) begin
            state_q <= ST_RUNNING;
            ssr_q   <= SSR_START;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ssr       = ssr_q;
  assign bus.tick      = tick_q;
  assign bus.wrap      = wrap_q;
  assign bus.lap_valid = lap_valid_q;
  assign bus.lap_count = lap_count_q;
  assign bus.state     = state_q;

endmodule
